// File: rtl/counter_4bit.sv
// counter_4bit
//
// Purpose:
//   Synchronous up/down counter with a count enable and a direction select.
//   On every rising edge it clears, holds, increments or decrements a single
//   registered value. The value wraps modulo 2^WIDTH.
//
// Ports:
//   clk        system clock; every state update happens on its rising edge
//   reset      synchronous active-low reset; a 0 at an edge clears count
//   enable     1 = count, 0 = hold
//   count_dir  1 = up (increment), 0 = down (decrement)
//   count      current counter value, driven straight from the register
module counter_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             count_dir,
  output logic [WIDTH-1:0] count
);

  // Reset beats enable, and enable beats direction. The add and the subtract
  // stay at WIDTH bits, so the carry or borrow falls off and the value wraps.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (enable) begin
      if (count_dir) begin
        count <= count + WIDTH'(1);
      end else begin
        count <= count - WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_counter_4bit.sv
// tb_counter_4bit
//
// Purpose:
//   Directed-vector bench for counter_4bit. Each vector holds one set of
//   inputs and the count value, worked out by hand, that must appear after
//   the next rising edge.
//
// Ports:
//   none (top-level bench)
module tb_counter_4bit;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       count_dir;
  logic [3:0] count;

  int testsRun    = 0;
  int testsFailed = 0;

  counter_4bit #(.WIDTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .count_dir (count_dir),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with the value it is required to have.
  task automatic checkOutput(input string tag, input logic [3:0] actual,
                             input logic [3:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Drive the inputs between edges, then let one rising edge pass. The output
  // is read #1 after that edge and compared with the expected value.
  task automatic applyStimulus(input string tag, input logic rst,
                               input logic en, input logic dir,
                               input logic [3:0] expected);
    @(negedge clk);
    reset     = rst;
    enable    = en;
    count_dir = dir;
    @(posedge clk);
    #1;
    checkOutput(tag, count, expected);
  endtask

  // Each vector is reset, enable, dir, and the required count after the edge.
  typedef struct {
    string      tag;
    logic       rst;
    logic       en;
    logic       dir;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    count_dir = 1'b0;

    // Reset from an arbitrary power-up value, then release with enable low.
    vecs.push_back('{"reset_first",   1'b0, 1'b1, 1'b1, 4'd0});
    vecs.push_back('{"reset_second",  1'b0, 1'b1, 1'b1, 4'd0});
    vecs.push_back('{"release_hold",  1'b1, 1'b0, 1'b1, 4'd0});
    vecs.push_back('{"release_hold2", 1'b1, 1'b0, 0,    4'd0});

    // Count up for 17 edges: 1..15, then a wrap to 0, then 1.
    for (int i = 1; i <= 17; i++) begin
      vecs.push_back('{$sformatf("up_%0d", i), 1'b1, 1'b1, 1'b1,
                       4'(i % 16)});
    end

    // Clear, then count down through the wrap: 15, 14, 13.
    vecs.push_back('{"clr_dn",   1'b0, 1'b0, 1'b0, 4'd0});
    vecs.push_back('{"down_wrap", 1'b1, 1'b1, 1'b0, 4'd15});
    vecs.push_back('{"down_14",   1'b1, 1'b1, 1'b0, 4'd14});
    vecs.push_back('{"down_13",   1'b1, 1'b1, 1'b0, 4'd13});

    // Clear, count up to 3, then reverse to 2, 1, 0.
    vecs.push_back('{"clr_dir",  1'b0, 1'b1, 1'b0, 4'd0});
    vecs.push_back('{"dir_up1",  1'b1, 1'b1, 1'b1, 4'd1});
    vecs.push_back('{"dir_up2",  1'b1, 1'b1, 1'b1, 4'd2});
    vecs.push_back('{"dir_up3",  1'b1, 1'b1, 1'b1, 4'd3});
    vecs.push_back('{"dir_dn2",  1'b1, 1'b1, 1'b0, 4'd2});
    vecs.push_back('{"dir_dn1",  1'b1, 1'b1, 1'b0, 4'd1});
    vecs.push_back('{"dir_dn0",  1'b1, 1'b1, 1'b0, 4'd0});

    // Count up 0 -> 7, hold for two edges (with dir toggled), then resume to 8.
    for (int i = 1; i <= 7; i++) begin
      vecs.push_back('{$sformatf("to7_%0d", i), 1'b1, 1'b1, 1'b1, 4'(i)});
    end
    vecs.push_back('{"hold_a",   1'b1, 1'b0, 1'b0, 4'd7});
    vecs.push_back('{"hold_b",   1'b1, 1'b0, 1'b1, 4'd7});
    vecs.push_back('{"resume_8", 1'b1, 1'b1, 1'b1, 4'd8});

    // Reset priority: at 9 with enable high, reset clears regardless of dir.
    vecs.push_back('{"to_9",       1'b1, 1'b1, 1'b1, 4'd9});
    vecs.push_back('{"rst_pri_d0", 1'b0, 1'b1, 1'b0, 4'd0});
    vecs.push_back('{"after_rst1", 1'b1, 1'b1, 1'b1, 4'd1});
    vecs.push_back('{"after_rst2", 1'b1, 1'b1, 1'b1, 4'd2});
    vecs.push_back('{"rst_pri_d1", 1'b0, 1'b1, 1'b1, 4'd0});
    vecs.push_back('{"post_rst1",  1'b1, 1'b1, 1'b1, 4'd1});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].tag, vecs[i].rst, vecs[i].en, vecs[i].dir,
                    vecs[i].exp);
    end

    // A reset pulse that starts and ends between two edges must not clear
    // count. The count is 1 here, and enable is low so it should stay at 1.
    @(negedge clk);
    enable = 1'b0;
    #1 reset = 1'b0;
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("glitch_rst", count, 4'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
